// File: rtl/dma_pkg.sv
// Shared types for the DMA scheduler: packet, response and host command layouts.
package dma_pkg;

    localparam int DMA_ID_W  = 3;
    localparam int DMA_ADDR  = 16;
    localparam int DMA_DATA  = 32;
    localparam int DMA_DLY_W = 11;

    typedef logic [DMA_ID_W-1:0] dma_id_t;

    typedef struct packed {
        logic                 valid;
        dma_id_t              id;
        logic [DMA_ADDR-1:0]  addr;
        logic [DMA_DLY_W-1:0] delay;
    } DMA_RPKT;

    typedef struct packed {
        logic                 valid;
        dma_id_t              id;
        logic [DMA_ADDR-1:0]  addr;
        logic [DMA_DLY_W-1:0] delay;
        logic [DMA_DATA-1:0]  data_i;
    } DMA_WPKT;

    typedef struct packed {
        dma_id_t id;
        logic    finish;
    } DMA_RESP;

    typedef struct packed {
        logic                 is_wr;
        dma_id_t              id;
        logic [DMA_ADDR-1:0]  addr;
        logic [DMA_DLY_W-1:0] delay;
        logic [DMA_DATA-1:0]  data;
    } DMA_CMD;

    function automatic DMA_RPKT mk_rpkt(input DMA_CMD c);
        DMA_RPKT p;
        p.valid = 1'b1;
        p.id    = c.id;
        p.addr  = c.addr;
        p.delay = c.delay;
        return p;
    endfunction

    function automatic DMA_WPKT mk_wpkt(input DMA_CMD c);
        DMA_WPKT p;
        p.valid  = 1'b1;
        p.id     = c.id;
        p.addr   = c.addr;
        p.delay  = c.delay;
        p.data_i = c.data;
        return p;
    endfunction

endpackage

// File: rtl/dma_cmd_fifo.sv
// Command queue for the DMA scheduler: power-of-two circular buffer with
// synchronous flush; flush wins over a same-cycle push.
module dma_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_head    = r_mem[r_rd];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + AW'(1);
            if (w_do_pop)  r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

endmodule

// File: rtl/dma_sched.sv
// Head-of-chain DMA command scheduler: in-order issue, per-engine read busy tracking.
// Optional per-read watchdog enabled by defining DMA_SCHED_TIMEOUT_EN.
module dma_sched
    import dma_pkg::*;
#(
    parameter int NUM_DMA    = 6,
    parameter int FIFO_DEPTH = 8
`ifdef DMA_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 2048
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  DMA_CMD                     cmd,
    input  logic                       flush,
    output DMA_RPKT                    rpkt_o,
    output DMA_WPKT                    wpkt_o,
    input  DMA_RESP                    res_i,
    output logic                       done_valid,
    output logic [$clog2(NUM_DMA)-1:0] done_id,
    output logic                       err,
    output logic [NUM_DMA-1:0]         busy,
    output logic                       timeout
);

    localparam int IDW = $clog2(NUM_DMA);

    logic               r_run;
    logic [NUM_DMA-1:0] r_busy;
    logic [NUM_DMA-1:0] w_busy_nxt;
    DMA_RPKT            r_rpkt;
    DMA_WPKT            r_wpkt;
    logic               r_done_valid;
    logic [IDW-1:0]     r_done_id;
    logic               r_err;

    DMA_CMD             w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_acc;
    logic               w_cmd_ok;
    logic               w_push;
    logic               w_issue;
    logic               w_fin_ok;
    logic               w_fin_bad;

    // cmd_ready stays low until the first edge after reset release.
    assign cmd_ready = r_run && !w_full;
    assign w_acc     = cmd_valid && cmd_ready;
    assign w_cmd_ok  = int'(cmd.id) < NUM_DMA;
    assign w_push    = w_acc && w_cmd_ok;
    assign w_issue   = !w_empty && !r_busy[w_head.id];
    assign w_fin_ok  = res_i.finish && (int'(res_i.id) < NUM_DMA) && r_busy[res_i.id];
    assign w_fin_bad = res_i.finish && !w_fin_ok;

    dma_cmd_fifo #(
        .WIDTH ($bits(DMA_CMD)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_issue),
        .i_flush (flush),
        .i_data  (w_push ? cmd : '0),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

`ifdef DMA_SCHED_TIMEOUT_EN
    logic [15:0]        r_wd [NUM_DMA];
    logic [NUM_DMA-1:0] r_to_pend;
    logic [NUM_DMA-1:0] w_exp;
    logic [NUM_DMA-1:0] w_to_all;
    logic [NUM_DMA-1:0] w_to_clr;
    logic               w_to_fire;
    logic [IDW-1:0]     w_to_id;
    logic               r_timeout;

    // A finish landing on the expiry cycle takes precedence over the watchdog.
    always_comb begin
        w_exp = '0;
        for (int i = 0; i < NUM_DMA; i++) begin
            if (r_busy[i] && (r_wd[i] == 16'(TIMEOUT_CYC - 1)) &&
                !(w_fin_ok && (int'(res_i.id) == i)))
                w_exp[i] = 1'b1;
        end
    end

    // Report one expiry per cycle, lowest id first; a completion owns done_id.
    always_comb begin
        w_to_all  = r_to_pend | w_exp;
        w_to_fire = 1'b0;
        w_to_id   = '0;
        w_to_clr  = '0;
        if (!w_fin_ok) begin
            for (int i = NUM_DMA - 1; i >= 0; i--) begin
                if (w_to_all[i]) begin
                    w_to_fire = 1'b1;
                    w_to_id   = IDW'(i);
                end
            end
        end
        if (w_to_fire) w_to_clr[w_to_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DMA; i++) r_wd[i] <= '0;
            r_to_pend <= '0;
            r_timeout <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DMA; i++) begin
                if (w_issue && !w_head.is_wr && (int'(w_head.id) == i))
                    r_wd[i] <= '0;
                else if (r_busy[i])
                    r_wd[i] <= r_wd[i] + 16'd1;
            end
            r_to_pend <= w_to_all & ~w_to_clr;
            r_timeout <= w_to_fire;
        end
    end

    assign timeout = r_timeout;
`else
    logic [NUM_DMA-1:0] w_exp;
    logic               w_to_fire;
    logic [IDW-1:0]     w_to_id;

    assign w_exp     = '0;
    assign w_to_fire = 1'b0;
    assign w_to_id   = '0;
    assign timeout   = 1'b0;
`endif

    // Completion/expiry clears and read issue can never hit the same engine in one cycle.
    always_comb begin
        w_busy_nxt = r_busy & ~w_exp;
        if (w_fin_ok) w_busy_nxt[res_i.id] = 1'b0;
        if (w_issue && !w_head.is_wr) w_busy_nxt[w_head.id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run        <= 1'b0;
            r_busy       <= '0;
            r_rpkt       <= '0;
            r_wpkt       <= '0;
            r_done_valid <= 1'b0;
            r_done_id    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_run        <= 1'b1;
            r_busy       <= w_busy_nxt;
            r_rpkt       <= '0;
            r_wpkt       <= '0;
            if (w_issue) begin
                if (w_head.is_wr) r_wpkt <= mk_wpkt(w_head);
                else              r_rpkt <= mk_rpkt(w_head);
            end
            r_done_valid <= w_fin_ok;
            if (w_fin_ok)       r_done_id <= res_i.id[IDW-1:0];
            else if (w_to_fire) r_done_id <= w_to_id;
            else                r_done_id <= '0;
            r_err        <= (w_acc && !w_cmd_ok) || w_fin_bad;
        end
    end

    assign rpkt_o     = r_rpkt;
    assign wpkt_o     = r_wpkt;
    assign done_valid = r_done_valid;
    assign done_id    = r_done_id;
    assign err        = r_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_dma_sched.sv
// Scoreboard bench for dma_sched: expected packets/completions queued at drive time,
// popped by a negedge monitor when the DUT emits them.
module tb_dma_sched;
    import dma_pkg::*;

    localparam int NUM_DMA = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid;
    logic          cmd_ready;
    DMA_CMD        cmd;
    logic          flush;
    DMA_RPKT       rpkt_o;
    DMA_WPKT       wpkt_o;
    DMA_RESP       res_i;
    logic          done_valid;
    logic [2:0]    done_id;
    logic          err;
    logic [NUM_DMA-1:0] busy;
    logic          timeout;

    int     n_chk = 0;
    int     n_fail = 0;
    int     err_cnt = 0;
    DMA_CMD exp_pkt_q[$];
    int     exp_done_q[$];
    int     exp_to_q[$];
    DMA_CMD mon_c;
    int     mon_id;

    always #5 clk = ~clk;

    dma_sched #(
        .NUM_DMA    (NUM_DMA),
        .FIFO_DEPTH (8)
`ifdef DMA_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .flush      (flush),
        .rpkt_o     (rpkt_o),
        .wpkt_o     (wpkt_o),
        .res_i      (res_i),
        .done_valid (done_valid),
        .done_id    (done_id),
        .err        (err),
        .busy       (busy),
        .timeout    (timeout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic wr, input int id, input int addr, input int dly,
                        input int data, input bit track);
        DMA_CMD c;
        int     k;
        c.is_wr = wr;
        c.id    = 3'(id);
        c.addr  = 16'(addr);
        c.delay = 11'(dly);
        c.data  = 32'(data);
        cmd       = c;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            tick();
            k++;
        end
        check("ready_wait", 64'(cmd_ready), 64'(1));
        if (cmd_ready && track && id < NUM_DMA) exp_pkt_q.push_back(c);
        tick();
        cmd_valid = 1'b0;
        cmd       = '0;
    endtask

    task automatic resp(input int id, input bit exp_done);
        res_i.id     = 3'(id);
        res_i.finish = 1'b1;
        if (exp_done) exp_done_q.push_back(id);
        tick();
        res_i = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rpkt_o.valid || wpkt_o.valid) begin
                check("one_pkt", 64'(rpkt_o.valid & wpkt_o.valid), 64'(0));
                if (exp_pkt_q.size() == 0) begin
                    check("unexp_pkt", 64'({rpkt_o.valid, wpkt_o.valid}), 64'(0));
                end else begin
                    mon_c = exp_pkt_q.pop_front();
                    if (mon_c.is_wr) begin
                        check("wpkt", 64'(wpkt_o), 64'({1'b1, mon_c.id, mon_c.addr, mon_c.delay, mon_c.data}));
                        check("rpkt_quiet", 64'(rpkt_o), 64'(0));
                    end else begin
                        check("rpkt", 64'(rpkt_o), 64'({1'b1, mon_c.id, mon_c.addr, mon_c.delay}));
                        check("wpkt_quiet", 64'(wpkt_o), 64'(0));
                    end
                end
            end else begin
                check("idle_r", 64'(rpkt_o), 64'(0));
                check("idle_w", 64'(wpkt_o), 64'(0));
            end
            if (done_valid) begin
                if (exp_done_q.size() == 0) check("unexp_done", 64'(done_valid), 64'(0));
                else begin
                    mon_id = exp_done_q.pop_front();
                    check("done_id", 64'(done_id), 64'(mon_id));
                end
            end
            if (timeout) begin
                if (exp_to_q.size() == 0) check("unexp_timeout", 64'(timeout), 64'(0));
                else begin
                    mon_id = exp_to_q.pop_front();
                    check("timeout_id", 64'(done_id), 64'(mon_id));
                end
            end
            if (err) err_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "tb_dma_sched time limit");
    end

    initial begin
        cmd_valid = 1'b0;
        cmd       = '0;
        flush     = 1'b0;
        res_i     = '0;
        tick(3);
        check("rst_ready", 64'(cmd_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rpkt", 64'(rpkt_o), 64'(0));
        check("rst_wpkt", 64'(wpkt_o), 64'(0));
        check("rst_outs", 64'({done_valid, err, timeout}), 64'(0));
        rst_n = 1'b1;
        tick(2);
        check("ready_after_rst", 64'(cmd_ready), 64'(1));

        // Single read: latency, busy, completion
        send(1'b0, 2, 'h40, 0, 0, 1'b1);
        check("t1_lat_n1", 64'(rpkt_o.valid), 64'(0));
        tick();
        check("t1_lat_n2", 64'(rpkt_o.valid), 64'(1));
        check("t1_busy", 64'(busy), 64'(6'b000100));
        tick(5);
        check("t1_busy_hold", 64'(busy), 64'(6'b000100));
        resp(2, 1'b1);
        check("t1_done", 64'(done_valid), 64'(1));
        check("t1_busy_clr", 64'(busy), 64'(0));
        tick();

        // Write then read to the same engine
        send(1'b1, 0, 'h10, 3, 'hA5, 1'b1);
        send(1'b0, 0, 'h20, 0, 0, 1'b1);
        check("t2_wr_out", 64'(wpkt_o.valid), 64'(1));
        check("t2_busy_wr", 64'(busy), 64'(0));
        tick();
        check("t2_rd_out", 64'(rpkt_o.valid), 64'(1));
        check("t2_busy_rd", 64'(busy), 64'(6'b000001));
        tick(2);
        resp(0, 1'b1);
        tick();

        // Head-of-line blocking and one-cycle bubble after finish
        send(1'b0, 1, 'h100, 0, 0, 1'b1);
        send(1'b0, 1, 'h104, 5, 0, 1'b1);
        send(1'b1, 3, 'h108, 0, 'h1234, 1'b1);
        tick(4);
        check("t3_stall", 64'(exp_pkt_q.size()), 64'(2));
        check("t3_busy", 64'(busy), 64'(6'b000010));
        resp(1, 1'b1);
        check("t3_bubble", 64'(rpkt_o.valid), 64'(0));
        tick();
        check("t3_rd2", 64'(rpkt_o.valid), 64'(1));
        check("t3_busy2", 64'(busy), 64'(6'b000010));
        tick();
        check("t3_wr", 64'(wpkt_o.valid), 64'(1));
        tick();
        resp(1, 1'b1);
        tick();

        // Fill behind a busy engine, then flush
        send(1'b0, 4, 'h200, 0, 0, 1'b1);
        tick(2);
        for (int i = 0; i < 8; i++) send(1'b1, 4, 'h300 + i, 0, i, 1'b0);
        check("t4_full", 64'(cmd_ready), 64'(0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_flush_ready", 64'(cmd_ready), 64'(1));
        check("t4_busy", 64'(busy), 64'(6'b010000));
        tick(4);
        check("t4_no_pkts", 64'(exp_pkt_q.size()), 64'(0));
        resp(4, 1'b1);
        tick();

        // Error pulses
        send(1'b0, 6, 'h300, 0, 0, 1'b1);
        check("t5_err_cmd", 64'(err), 64'(1));
        tick();
        check("t5_err_clr", 64'(err), 64'(0));
        resp(4, 1'b0);
        check("t5_err_resp", 64'(err), 64'(1));
        check("t5_no_done", 64'(done_valid), 64'(0));
        tick();
        cmd.is_wr    = 1'b0;
        cmd.id       = 3'd7;
        cmd.addr     = 16'h500;
        cmd_valid    = 1'b1;
        res_i.id     = 3'd5;
        res_i.finish = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd       = '0;
        res_i     = '0;
        check("t5_err_both", 64'(err), 64'(1));
        tick();
        check("t5_err_single", 64'(err), 64'(0));
        check("t5_busy", 64'(busy), 64'(0));

`ifdef DMA_SCHED_TIMEOUT_EN
        // Watchdog expiry, then finish racing the expiry cycle
        send(1'b0, 5, 'h400, 0, 0, 1'b1);
        tick();
        check("t6_issue", 64'(rpkt_o.valid), 64'(1));
        exp_to_q.push_back(5);
        tick(16);
        check("t6_timeout", 64'(timeout), 64'(1));
        check("t6_to_id", 64'(done_id), 64'(5));
        check("t6_to_nodone", 64'(done_valid), 64'(0));
        check("t6_busy", 64'(busy), 64'(0));
        tick();
        send(1'b0, 5, 'h404, 0, 0, 1'b1);
        tick();
        check("t6b_issue", 64'(rpkt_o.valid), 64'(1));
        tick(15);
        resp(5, 1'b1);
        check("t6b_done", 64'(done_valid), 64'(1));
        check("t6b_no_to", 64'(timeout), 64'(0));
        tick(3);
        check("t6_to_q", 64'(exp_to_q.size()), 64'(0));
`endif

        tick(5);
        check("end_pkt_q", 64'(exp_pkt_q.size()), 64'(0));
        check("end_done_q", 64'(exp_done_q.size()), 64'(0));
        check("err_count", 64'(err_cnt), 64'(3));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
